// File: rtl/seg_scan_drv.sv
// Multiplexed N-digit 8-segment scanner: hex or raw segments, PWM brightness, anti-ghost guard,
// leading-zero blanking. Single clock with an internal free-running slot counter.
module seg_scan_drv #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned DIV_BITS    = 16,
  parameter int unsigned BRIGHT_BITS = 3,
  parameter int unsigned GUARD       = 4,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DRN_ACT_LOW = 1'b0
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic [8*N_DIGITS-1:0]   i_Data,
  input  logic [N_DIGITS-1:0]     i_DP,
  input  logic                    i_Raw,
  input  logic                    i_LZB,
  input  logic                    i_Load,
  input  logic [BRIGHT_BITS-1:0]  i_Bright,
  output logic                    o_Pending,
  output logic                    o_Frame,
  output logic [N_DIGITS-1:0]     o_Drains,
  output logic [7:0]              o_Segs
);

  localparam int unsigned          DW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DW-1:0]        LastDigit = DW'(N_DIGITS - 1);
  localparam logic [DIV_BITS-1:0]  GuardCnt  = DIV_BITS'(GUARD);
  localparam logic [N_DIGITS-1:0]  DrnOff    = DRN_ACT_LOW ? '1 : '0;
  localparam logic [7:0]           SegOff    = SEG_ACT_LOW ? 8'hFF : 8'h00;

  typedef struct packed {
    logic [8*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic                  raw;
    logic                  lzb;
  } frame_t;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [DW-1:0]       d_q, d_d;
  frame_t              shadow_q, shadow_d, disp_q, disp_d, in_frame;
  logic                pending_q, pending_d, frame_q, frame_d;
  logic [N_DIGITS-1:0] drains_q, drains_d, drn_on;
  logic [7:0]          segs_q, segs_d, seg_on, raw_byte;
  logic [3:0]          nib;
  logic                dp_bit, nz_above, blank, drive, slot_end, frame_end;

  always_comb begin
    slot_end  = &cnt_q;
    frame_end = slot_end && (d_q == LastDigit);
    cnt_d     = cnt_q + 1'b1;
    d_d       = d_q;
    if (slot_end) begin
      d_d = (d_q == LastDigit) ? '0 : d_q + 1'b1;
    end
    in_frame.data = i_Data;
    in_frame.dp   = i_DP;
    in_frame.raw  = i_Raw;
    in_frame.lzb  = i_LZB;
    shadow_d  = i_Load ? in_frame : shadow_q;
    // A load on the boundary clock goes straight through shadow_d into the display.
    disp_d    = frame_end ? shadow_d : disp_q;
    pending_d = frame_end ? 1'b0 : (i_Load | pending_q);
    frame_d   = frame_end;
  end

  always_comb begin
    raw_byte = '0;
    nib      = '0;
    dp_bit   = 1'b0;
    nz_above = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (DW'(k) == d_q) begin
        raw_byte = disp_q.data[8*k +: 8];
        nib      = disp_q.data[4*k +: 4];
        dp_bit   = disp_q.dp[k];
      end
      if (DW'(k) >= d_q && disp_q.data[4*k +: 4] != 4'h0) begin
        nz_above = 1'b1;
      end
    end
    blank    = disp_q.lzb && (d_q != '0) && !nz_above;
    seg_on   = disp_q.raw ? raw_byte : {dp_bit, blank ? 7'h00 : hex7(nib)};
    segs_d   = SEG_ACT_LOW ? ~seg_on : seg_on;
    drive    = (cnt_q >= GuardCnt) && (cnt_q[DIV_BITS-1 -: BRIGHT_BITS] <= i_Bright);
    drn_on   = drive ? (N_DIGITS'(1) << d_q) : '0;
    drains_d = DRN_ACT_LOW ? ~drn_on : drn_on;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      cnt_q     <= '0;
      d_q       <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      drains_q  <= DrnOff;
      segs_q    <= SegOff;
    end else begin
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      drains_q  <= drains_d;
      segs_q    <= segs_d;
    end
  end

  assign o_Pending = pending_q;
  assign o_Frame   = frame_q;
  assign o_Drains  = drains_q;
  assign o_Segs    = segs_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv (4 digits, 16-clock slots, 2-bit brightness, guard 1).
// Expectations are queued per clock and compared after each rising edge.
module tb_seg_scan_drv;

  logic        clk = 1'b0;
  logic        i_RST = 1'b1;
  logic [31:0] i_Data = '0;
  logic [3:0]  i_DP = '0;
  logic        i_Raw = 1'b0;
  logic        i_LZB = 1'b0;
  logic        i_Load = 1'b0;
  logic [1:0]  i_Bright = 2'd3;
  logic        o_Pending, o_Frame;
  logic [3:0]  o_Drains;
  logic [7:0]  o_Segs;

  always #5 clk = ~clk;

  seg_scan_drv #(
    .N_DIGITS(4), .DIV_BITS(4), .BRIGHT_BITS(2), .GUARD(1),
    .SEG_ACT_LOW(1'b1), .DRN_ACT_LOW(1'b0)
  ) dut (
    .i_CLK(clk), .i_RST(i_RST), .i_Data(i_Data), .i_DP(i_DP), .i_Raw(i_Raw),
    .i_LZB(i_LZB), .i_Load(i_Load), .i_Bright(i_Bright), .o_Pending(o_Pending),
    .o_Frame(o_Frame), .o_Drains(o_Drains), .o_Segs(o_Segs)
  );

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [7:0]  exp;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         on_cycles = 0;
  logic [1:0] bright_m = 2'd3;
  logic [7:0] cur_segs [4];

  function automatic logic [7:0] observe(input int unsigned sel);
    case (sel)
      0:       return {4'b0, o_Drains};
      1:       return o_Segs;
      2:       return {7'b0, o_Frame};
      3:       return {7'b0, o_Pending};
      default: return on_cycles[7:0];
    endcase
  endfunction

  // Expected drain pattern for slot counter value cnt on digit d.
  function automatic logic [3:0] exp_drn(input int cnt, input int d, input logic [1:0] b);
    logic [3:0] r;
    r = 4'b0000;
    if (cnt >= 1 && (cnt / 4) <= int'(b)) r = 4'b0001 << d;
    return r;
  endfunction

  task automatic push(input string tag, input int unsigned sel, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s (cycle %0d): observed %h expected %h", e.tag, cyc, obs, e.exp);
      end
    end
  endtask

  // Each clock: outputs after the edge reflect the scan state held before it (state index cyc).
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      int s, cnt, d;
      s   = cyc;
      cnt = s % 16;
      d   = (s / 16) % 4;
      push("drains", 0, {4'b0, exp_drn(cnt, d, bright_m)});
      push("segs", 1, cur_segs[d]);
      push("frame", 2, {7'b0, ((s % 64) == 63)});
      @(posedge clk);
      #1;
      cyc++;
      if (o_Drains != 4'b0) on_cycles++;
      check_sb();
    end
  endtask

  task automatic reset_dut(input int n);
    i_RST = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    push("rst_drains", 0, 8'h00);
    push("rst_segs", 1, 8'hFF);
    push("rst_frame", 2, 8'h00);
    push("rst_pending", 3, 8'h00);
    check_sb();
    i_RST = 1'b0;
    cyc   = 0;
  endtask

  task automatic load_run(input logic [31:0] data, input logic [3:0] dp, input logic raw,
                          input logic lzb);
    i_Data = data;
    i_DP   = dp;
    i_Raw  = raw;
    i_LZB  = lzb;
    i_Load = 1'b1;
    run(1);
    i_Load = 1'b0;
  endtask

  task automatic check_pending(input logic exp);
    push("pending", 3, {7'b0, exp});
    check_sb();
  endtask

  task automatic set_segs(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                          input logic [7:0] s3);
    cur_segs[0] = s0;
    cur_segs[1] = s1;
    cur_segs[2] = s2;
    cur_segs[3] = s3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_segs(8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Reset values, then first frame pulse 64 clocks after release.
    reset_dut(3);
    run(64);

    // Mid-frame load: pending until the boundary, old digits until then.
    run(20);
    load_run(32'h0000_1234, 4'b0000, 1'b0, 1'b0);
    check_pending(1'b1);
    run(43);
    check_pending(1'b0);
    set_segs(8'h99, 8'hB0, 8'hA4, 8'hF9);
    on_cycles = 0;
    run(64);
    push("on_cycles_b3", 4, 8'd60);
    check_sb();

    // Minimum brightness: 3 active clocks per slot.
    i_Bright  = 2'd0;
    bright_m  = 2'd0;
    on_cycles = 0;
    run(64);
    push("on_cycles_b0", 4, 8'd12);
    check_sb();
    i_Bright = 2'd3;
    bright_m = 2'd3;

    // Leading-zero blanking with dp on a blanked digit.
    load_run(32'h0000_0050, 4'b1000, 1'b0, 1'b1);
    check_pending(1'b1);
    run(63);
    check_pending(1'b0);
    set_segs(8'hC0, 8'h92, 8'hFF, 8'h7F);
    run(64);

    // Raw mode loaded on the boundary clock: shown this frame, never pending.
    run(63);
    load_run(32'hFF00_0680, 4'b1111, 1'b1, 1'b1);
    check_pending(1'b0);
    set_segs(8'h7F, 8'hF9, 8'hFF, 8'h00);
    run(64);

    // Mid-slot reset with data pending.
    run(5);
    load_run(32'h0000_00AB, 4'b0000, 1'b0, 1'b0);
    check_pending(1'b1);
    run(3);
    reset_dut(1);
    set_segs(8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Back-to-back loads: the last one wins at the boundary.
    run(10);
    load_run(32'h0000_1111, 4'b0000, 1'b0, 1'b0);
    load_run(32'h0000_0F0F, 4'b0000, 1'b0, 1'b0);
    check_pending(1'b1);
    run(52);
    check_pending(1'b0);
    set_segs(8'h8E, 8'hC0, 8'h8E, 8'hC0);
    run(64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
